// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write tracker with stall and forwarding-slot select.
// Optional stall statistics counters: define HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int REG_COUNT = 32,
    parameter int STAGES    = 3,
    parameter int ID_W      = $clog2(REG_COUNT),
    parameter int ST_W      = $clog2(STAGES + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            issue_valid,
    input  logic            read1_need,
    input  logic [ID_W-1:0] read1_id,
    input  logic [ST_W-1:0] read1_stage,
    input  logic            read2_need,
    input  logic [ID_W-1:0] read2_id,
    input  logic [ST_W-1:0] read2_stage,
    input  logic            write_en,
    input  logic [ID_W-1:0] write_id,
    input  logic [ST_W-1:0] write_avail,
    input  logic            kill,
    output logic            stall,
    output logic [ST_W-1:0] fwd1_slot,
    output logic [ST_W-1:0] fwd2_slot
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     load_use_events
`endif
);

    // Highest slot index, widened so k + stage never wraps.
    localparam logic [ST_W:0] LAST = (ST_W + 1)'(STAGES);

    // Slot 1 is the instruction now in EX, slot STAGES the one in WB.
    logic            slot_v  [1:STAGES];
    logic [ID_W-1:0] slot_id [1:STAGES];
    logic [ST_W-1:0] slot_av [1:STAGES];

    logic [ST_W:0] res1;
    logic [ST_W:0] res2;
    logic          hazard1;
    logic          hazard2;
    logic          enter;

    // Returns {hazard, fwd_slot} for one source operand.
    // The youngest matching writer (smallest slot index) wins.
    function automatic logic [ST_W:0] resolve(
        input logic            need,
        input logic [ID_W-1:0] id,
        input logic [ST_W-1:0] stage
    );
        logic            hit;
        logic [ST_W-1:0] av;
        logic [ST_W:0]   pos;
        logic [ST_W:0]   at;
        hit     = 1'b0;
        av      = '0;
        pos     = '0;
        resolve = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (slot_v[k] && slot_id[k] == id) begin
                hit = 1'b1;
                av  = slot_av[k];
                pos = (ST_W + 1)'(k);
            end
        end
        // Slot the writer will occupy when this source is consumed.
        at = pos + {1'b0, stage};
        if (need && id != '0 && hit) begin
            if ({1'b0, av} >= at) begin
                resolve = {1'b1, {ST_W{1'b0}}};
            end else if (at <= LAST) begin
                resolve = {1'b0, at[ST_W-1:0]};
            end
        end
    endfunction

    // Per-source hit search against the current slot contents.
    always_comb begin
        res1 = resolve(issue_valid & read1_need, read1_id, read1_stage);
        res2 = resolve(issue_valid & read2_need, read2_id, read2_stage);
    end

    assign hazard1   = res1[ST_W];
    assign hazard2   = res2[ST_W];
    assign fwd1_slot = res1[ST_W-1:0];
    assign fwd2_slot = res2[ST_W-1:0];

    // A killed instruction never waits; it is discarded anyway.
    assign stall = (hazard1 | hazard2) & ~kill;

    // Stalled or killed issues enter the scoreboard as bubbles.
    assign enter = issue_valid & write_en & (write_id != '0)
                 & ~stall & ~kill;

    // Valid bits: cleared on reset, otherwise shift one slot per cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 1; k <= STAGES; k++) begin
                slot_v[k] <= 1'b0;
            end
        end else begin
            slot_v[1] <= enter;
            for (int k = 2; k <= STAGES; k++) begin
                slot_v[k] <= slot_v[k-1];
            end
        end
    end

    // Payload shifts unconditionally; it is ignored whenever valid is low.
    always_ff @(posedge clock) begin
        slot_id[1] <= write_id;
        slot_av[1] <= write_avail;
        for (int k = 2; k <= STAGES; k++) begin
            slot_id[k] <= slot_id[k-1];
            slot_av[k] <= slot_av[k-1];
        end
    end

    // Out-of-range stage, availability or register ids are illegal inputs.
    always_ff @(posedge clock) begin
        if (reset_n && issue_valid) begin
            if (read1_need) begin
                assert (int'(read1_stage) <= STAGES)
                    else $error("hazard_scoreboard: read1_stage out of range");
                assert (int'(read1_id) < REG_COUNT)
                    else $error("hazard_scoreboard: read1_id out of range");
            end
            if (read2_need) begin
                assert (int'(read2_stage) <= STAGES)
                    else $error("hazard_scoreboard: read2_stage out of range");
                assert (int'(read2_id) < REG_COUNT)
                    else $error("hazard_scoreboard: read2_id out of range");
            end
            if (write_en) begin
                assert (int'(write_avail) <= STAGES)
                    else $error("hazard_scoreboard: write_avail out of range");
                assert (int'(write_id) < REG_COUNT)
                    else $error("hazard_scoreboard: write_id out of range");
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic stall_q;

    // Saturating stall-cycle and stall-episode counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_q         <= 1'b0;
            stall_cycles    <= '0;
            load_use_events <= '0;
        end else begin
            stall_q <= stall;
            if (stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (stall && !stall_q && load_use_events != '1) begin
                load_use_events <= load_use_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus reset/statistics sequences.
// Define HAZARD_SCOREBOARD_STATS_EN to also check the counters.
module tb_hazard_scoreboard;

    localparam int ID_W = 5;
    localparam int ST_W = 2;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            issue_valid;
    logic            read1_need;
    logic [ID_W-1:0] read1_id;
    logic [ST_W-1:0] read1_stage;
    logic            read2_need;
    logic [ID_W-1:0] read2_id;
    logic [ST_W-1:0] read2_stage;
    logic            write_en;
    logic [ID_W-1:0] write_id;
    logic [ST_W-1:0] write_avail;
    logic            kill;
    logic            stall;
    logic [ST_W-1:0] fwd1_slot;
    logic [ST_W-1:0] fwd2_slot;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0]     stall_cycles;
    logic [31:0]     load_use_events;
`endif

    always #5 clock = ~clock;

    hazard_scoreboard dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .issue_valid     (issue_valid),
        .read1_need      (read1_need),
        .read1_id        (read1_id),
        .read1_stage     (read1_stage),
        .read2_need      (read2_need),
        .read2_id        (read2_id),
        .read2_stage     (read2_stage),
        .write_en        (write_en),
        .write_id        (write_id),
        .write_avail     (write_avail),
        .kill            (kill),
        .stall           (stall),
        .fwd1_slot       (fwd1_slot),
        .fwd2_slot       (fwd2_slot)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .load_use_events (load_use_events)
`endif
    );

    typedef struct {
        logic       iv;
        logic       n1;
        logic [4:0] id1;
        logic [1:0] s1;
        logic       n2;
        logic [4:0] id2;
        logic [1:0] s2;
        logic       we;
        logic [4:0] wid;
        logic [1:0] wav;
        logic       kl;
        logic       es;
        logic [1:0] ef1;
        logic [1:0] ef2;
        logic       cf;
    } vec_t;

    vec_t  tbl[$];
    string names[$];
    int    errors = 0;
    int    checks = 0;

    function automatic vec_t mk(
        logic iv,
        logic n1, logic [4:0] id1, logic [1:0] s1,
        logic n2, logic [4:0] id2, logic [1:0] s2,
        logic we, logic [4:0] wid, logic [1:0] wav,
        logic kl, logic es, logic [1:0] ef1, logic [1:0] ef2,
        logic cf
    );
        vec_t v;
        v.iv = iv;   v.n1 = n1;   v.id1 = id1; v.s1 = s1;
        v.n2 = n2;   v.id2 = id2; v.s2 = s2;
        v.we = we;   v.wid = wid; v.wav = wav; v.kl = kl;
        v.es = es;   v.ef1 = ef1; v.ef2 = ef2; v.cf = cf;
        return v;
    endfunction

    function automatic void add(string nm, vec_t v);
        tbl.push_back(v);
        names.push_back(nm);
    endfunction

    function automatic vec_t wr(logic [4:0] id, logic [1:0] av);
        return mk(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0,
                  1'b1, id, av, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    endfunction

    function automatic vec_t rd1(logic [4:0] id, logic [1:0] s,
                                 logic es, logic [1:0] ef);
        return mk(1'b1, 1'b1, id, s, 1'b0, 5'd0, 2'd0,
                  1'b0, 5'd0, 2'd0, 1'b0, es, ef, 2'd0, 1'b1);
    endfunction

    function automatic vec_t idle_v();
        return mk(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0,
                  1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    endfunction

    function automatic void idle(int n);
        for (int i = 0; i < n; i++) add("idle", idle_v());
    endfunction

    task automatic apply(vec_t v);
        issue_valid = v.iv;
        read1_need  = v.n1;
        read1_id    = v.id1;
        read1_stage = v.s1;
        read2_need  = v.n2;
        read2_id    = v.id2;
        read2_stage = v.s2;
        write_en    = v.we;
        write_id    = v.wid;
        write_avail = v.wav;
        kill        = v.kl;
    endtask

    task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk(string nm, logic es, logic [1:0] e1, logic [1:0] e2);
        cmp({nm, ".stall"}, 32'(stall), 32'(es));
        cmp({nm, ".fwd1"}, 32'(fwd1_slot), 32'(e1));
        cmp({nm, ".fwd2"}, 32'(fwd2_slot), 32'(e2));
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // ALU-to-ALU
        add("alu.wr", wr(5'd5, 2'd1));
        add("alu.rd", rd1(5'd5, 2'd1, 1'b0, 2'd2));
        idle(3);
        // Load-use
        add("lu.wr", wr(5'd8, 2'd2));
        add("lu.rd0", rd1(5'd8, 2'd1, 1'b1, 2'd0));
        add("lu.rd1", rd1(5'd8, 2'd1, 1'b0, 2'd3));
        idle(3);
        // Branch after ALU, avail 1
        add("br1.wr", wr(5'd3, 2'd1));
        add("br1.rd0", rd1(5'd3, 2'd0, 1'b1, 2'd0));
        add("br1.rd1", rd1(5'd3, 2'd0, 1'b0, 2'd2));
        idle(3);
        // Branch after load, avail 2
        add("br2.wr", wr(5'd3, 2'd2));
        add("br2.rd0", rd1(5'd3, 2'd0, 1'b1, 2'd0));
        add("br2.rd1", rd1(5'd3, 2'd0, 1'b1, 2'd0));
        add("br2.rd2", rd1(5'd3, 2'd0, 1'b0, 2'd3));
        idle(3);
        // Register zero
        add("r0.wr", wr(5'd0, 2'd2));
        add("r0.rd", mk(1'b1, 1'b1, 5'd0, 2'd1, 1'b1, 5'd0, 2'd0,
                        1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        idle(3);
        // Youngest writer
        add("yw.wr0", wr(5'd4, 2'd1));
        add("yw.wr1", wr(5'd4, 2'd1));
        add("yw.rd", rd1(5'd4, 2'd1, 1'b0, 2'd2));
        idle(3);
        // Kill with both sources; killed write must not enter
        add("kl.wr", wr(5'd6, 2'd2));
        add("kl.kill", mk(1'b1, 1'b1, 5'd6, 2'd1, 1'b1, 5'd6, 2'd1,
                          1'b1, 5'd9, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0));
        add("kl.rd", mk(1'b1, 1'b1, 5'd6, 2'd1, 1'b1, 5'd6, 2'd1,
                        1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1));
        add("kl.r9", mk(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 5'd9, 2'd1,
                        1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        idle(3);
        // Both sources, no kill
        add("bs.wr", wr(5'd6, 2'd2));
        add("bs.rd0", mk(1'b1, 1'b1, 5'd6, 2'd1, 1'b1, 5'd6, 2'd1,
                         1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1));
        add("bs.rd1", mk(1'b1, 1'b1, 5'd6, 2'd1, 1'b1, 5'd6, 2'd1,
                         1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1));
        idle(3);
        // Source 2 alone
        add("s2.wr", wr(5'd10, 2'd2));
        add("s2.rd0", mk(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 5'd10, 2'd1,
                         1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1));
        add("s2.rd1", mk(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 5'd10, 2'd1,
                         1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b1));
        idle(3);
        // Gating by issue_valid and read_need
        add("gt.wr", wr(5'd11, 2'd2));
        add("gt.noiv", mk(1'b0, 1'b1, 5'd11, 2'd1, 1'b0, 5'd0, 2'd0,
                          1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        add("gt.noneed", mk(1'b1, 1'b0, 5'd11, 2'd1, 1'b0, 5'd0, 2'd0,
                            1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        idle(3);
        // Forward slot past WB reads the register file
        add("pw.wr", wr(5'd12, 2'd1));
        idle(1);
        add("pw.rd", rd1(5'd12, 2'd2, 1'b0, 2'd0));
        idle(3);
        add("st3.wr", wr(5'd13, 2'd1));
        add("st3.rd", rd1(5'd13, 2'd3, 1'b0, 2'd0));
        idle(3);
        // Maximum availability: three stalls then register file
        add("mx.wr", wr(5'd14, 2'd3));
        add("mx.rd0", rd1(5'd14, 2'd0, 1'b1, 2'd0));
        add("mx.rd1", rd1(5'd14, 2'd0, 1'b1, 2'd0));
        add("mx.rd2", rd1(5'd14, 2'd0, 1'b1, 2'd0));
        add("mx.rd3", rd1(5'd14, 2'd0, 1'b0, 2'd0));
        idle(3);

        // Reset
        reset_n = 1'b0;
        apply(idle_v());
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst.idle", 1'b0, 2'd0, 2'd0);
        next_cycle();
        apply(rd1(5'd5, 2'd1, 1'b0, 2'd0));
        @(negedge clock);
        chk("rst.rd", 1'b0, 2'd0, 2'd0);
        next_cycle();

        // Table
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clock);
            cmp({names[i], ".stall"}, 32'(stall), 32'(tbl[i].es));
            if (tbl[i].cf) begin
                cmp({names[i], ".fwd1"}, 32'(fwd1_slot), 32'(tbl[i].ef1));
                cmp({names[i], ".fwd2"}, 32'(fwd2_slot), 32'(tbl[i].ef2));
            end
            next_cycle();
        end

        // Stall statistics from a fresh reset
        reset_n = 1'b0;
        apply(idle_v());
        next_cycle();
        reset_n = 1'b1;
        apply(wr(5'd8, 2'd2));
        next_cycle();
        apply(rd1(5'd8, 2'd1, 1'b0, 2'd0));
        @(negedge clock);
        cmp("st.lu.stall", 32'(stall), 32'd1);
        next_cycle();
        @(negedge clock);
        chk("st.lu.fwd", 1'b0, 2'd3, 2'd0);
        next_cycle();
        apply(wr(5'd3, 2'd2));
        next_cycle();
        apply(rd1(5'd3, 2'd0, 1'b0, 2'd0));
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk("st.br.fwd", 1'b0, 2'd3, 2'd0);
        next_cycle();
        apply(idle_v());
        @(negedge clock);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        cmp("st.cycles", stall_cycles, 32'd3);
        cmp("st.events", load_use_events, 32'd2);
`endif
        next_cycle();
        next_cycle();
        next_cycle();

        // Reset while all slots are full and a stall is active
        apply(wr(5'd1, 2'd3));
        next_cycle();
        apply(wr(5'd2, 2'd3));
        next_cycle();
        apply(wr(5'd3, 2'd3));
        next_cycle();
        apply(rd1(5'd3, 2'd0, 1'b0, 2'd0));
        @(negedge clock);
        cmp("mr.pre.stall", 32'(stall), 32'd1);
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        chk("mr.post.r3", 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        cmp("mr.cycles", stall_cycles, 32'd0);
        cmp("mr.events", load_use_events, 32'd0);
`endif
        next_cycle();
        apply(rd1(5'd1, 2'd0, 1'b0, 2'd0));
        @(negedge clock);
        chk("mr.post.r1", 1'b0, 2'd0, 2'd0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
